// File: rtl/rs_fifo_ctrl.sv
// rs_fifo_ctrl: sequencer for the received-symbol FIFO of the RS(16,8) decoder.
// Writes incoming symbols under backpressure, counts complete codewords, queues
// correction-ready requests and reads each codeword as a contiguous N-cycle burst.
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   in_valid/in_data   input symbol stream; in_ready accepts this cycle
//   corr_start         pulse: correction data for the oldest unread codeword ready
//   fifo_rst/wr/rd/din FIFO control (FIFO has sync active-high reset, 1-cycle read)
//   out_valid/sop/eop  status aligned with the FIFO's registered dataout
//   out_idx            symbol index of the current output
//   cw_stored          complete codewords buffered and unread
//   busy               read burst in progress
//   err_pend_ovf       sticky: request dropped because the pending counter was full
module rs_fifo_ctrl #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned N      = 16,
    parameter int unsigned DEPTH  = 132,
    parameter int unsigned PEND_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             corr_start,
    output logic             fifo_rst,
    output logic             fifo_wr,
    output logic             fifo_rd,
    output logic [WIDTH-1:0] fifo_din,
    output logic             out_valid,
    output logic             out_sop,
    output logic             out_eop,
    output logic [3:0]       out_idx,
    output logic [3:0]       cw_stored,
    output logic             busy,
    output logic             err_pend_ovf
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = 4;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic {S_IDLE, S_READ} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_fifo_rst;
    logic [CNT_W-1:0]   r_sym_cnt;
    logic [IDX_W-1:0]   r_wr_idx;
    logic [IDX_W-1:0]   r_rd_idx;
    logic [IDX_W-1:0]   w_rd_idx_nxt;
    logic [3:0]         r_cw_stored;
    logic [PEND_W-1:0]  r_pend;
    logic               r_err_pend_ovf;
    logic               r_out_valid;
    logic               r_out_sop;
    logic               r_out_eop;
    logic [IDX_W-1:0]   r_out_idx;
    logic               w_in_ready;
    logic               w_wr;
    logic               w_rd;
    logic               w_start;
    logic               w_can_start;
    logic               w_cw_done;

    // Write handshake and occupancy-based backpressure
    assign w_in_ready  = !r_fifo_rst && (r_sym_cnt < CNT_W'(DEPTH));
    assign w_wr        = in_valid && w_in_ready;
    assign w_rd        = (r_state == S_READ);
    assign w_cw_done   = w_wr && (r_wr_idx == IDX_LAST);
    assign w_can_start = (r_pend != '0) && (r_cw_stored != '0);

    assign in_ready     = w_in_ready;
    assign fifo_wr      = w_wr;
    assign fifo_din     = in_data;
    assign fifo_rd      = w_rd;
    assign busy         = w_rd;
    assign fifo_rst     = r_fifo_rst;
    assign cw_stored    = r_cw_stored;
    assign err_pend_ovf = r_err_pend_ovf;
    assign out_valid    = r_out_valid;
    assign out_sop      = r_out_sop;
    assign out_eop      = r_out_eop;
    assign out_idx      = r_out_idx;

    // FIFO reset: set asynchronously, held one cycle past reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fifo_rst <= 1'b1;
        else        r_fifo_rst <= 1'b0;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rd_idx <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rd_idx <= w_rd_idx_nxt;
        end
    end

    // FSM next state; burst start also fires back-to-back at the last symbol
    always_comb begin
        w_state_nxt  = r_state;
        w_start      = 1'b0;
        w_rd_idx_nxt = r_rd_idx;
        case (r_state)
            S_IDLE: begin
                w_rd_idx_nxt = '0;
                if (w_can_start) begin
                    w_state_nxt = S_READ;
                    w_start     = 1'b1;
                end
            end
            S_READ: begin
                if (r_rd_idx == IDX_LAST) begin
                    w_rd_idx_nxt = '0;
                    if (w_can_start) w_start     = 1'b1;
                    else             w_state_nxt = S_IDLE;
                end else begin
                    w_rd_idx_nxt = r_rd_idx + IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_rd_idx_nxt = '0;
            end
        endcase
    end

    // Symbol occupancy and write index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sym_cnt <= '0;
            r_wr_idx  <= '0;
        end else begin
            if (w_wr && !w_rd)      r_sym_cnt <= r_sym_cnt + CNT_W'(1);
            else if (w_rd && !w_wr) r_sym_cnt <= r_sym_cnt - CNT_W'(1);
            if (w_wr) r_wr_idx <= (r_wr_idx == IDX_LAST) ? '0 : r_wr_idx + IDX_W'(1);
        end
    end

    // Codeword and pending-request counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cw_stored    <= '0;
            r_pend         <= '0;
            r_err_pend_ovf <= 1'b0;
        end else begin
            if (w_cw_done && !w_start)      r_cw_stored <= r_cw_stored + 4'd1;
            else if (w_start && !w_cw_done) r_cw_stored <= r_cw_stored - 4'd1;

            if (corr_start && !w_start) begin
                if (r_pend == PEND_MAX) r_err_pend_ovf <= 1'b1;
                else                    r_pend <= r_pend + PEND_W'(1);
            end else if (w_start && !corr_start) begin
                r_pend <= r_pend - PEND_W'(1);
            end
        end
    end

    // Output tags delayed one cycle to line up with the FIFO's registered dataout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_idx   <= '0;
        end else begin
            r_out_valid <= w_rd;
            r_out_sop   <= w_rd && (r_rd_idx == '0);
            r_out_eop   <= w_rd && (r_rd_idx == IDX_LAST);
            r_out_idx   <= r_rd_idx;
        end
    end

endmodule

// File: tb/tb_rs_fifo_ctrl.sv
// Testbench for rs_fifo_ctrl with a behavioural 132-deep FIFO and an output scoreboard.
module tb_rs_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       corr_start = 1'b0;
    logic       in_ready, fifo_rst, fifo_wr, fifo_rd;
    logic [7:0] fifo_din;
    logic       out_valid, out_sop, out_eop, busy, err_pend_ovf;
    logic [3:0] out_idx, cw_stored;

    always #5 clk = ~clk;

    rs_fifo_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .corr_start(corr_start), .fifo_rst(fifo_rst),
        .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_din(fifo_din),
        .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_idx(out_idx), .cw_stored(cw_stored), .busy(busy),
        .err_pend_ovf(err_pend_ovf)
    );

    // Behavioural FIFO: sync active-high reset, registered read
    logic [7:0] mem [0:131];
    int         wp = 0, rp = 0;
    logic [7:0] fifo_dout = 8'h00;
    always @(posedge clk) begin
        if (fifo_rst) begin
            wp <= 0; rp <= 0; fifo_dout <= 8'h00;
        end else begin
            if (fifo_wr) begin
                mem[wp] <= fifo_din;
                wp <= (wp == 131) ? 0 : wp + 1;
            end
            if (fifo_rd) begin
                fifo_dout <= mem[rp];
                rp <= (rp == 131) ? 0 : rp + 1;
            end
        end
    end

    // Scoreboard
    typedef struct packed {
        logic [7:0] data;
        logic [3:0] idx;
        logic       sop;
        logic       eop;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mq[$];
    int         m_pend = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Release one expected codeword per pending request once 16 symbols are known
    task automatic model_update();
        while (m_pend > 0 && mq.size() >= 16) begin
            for (int i = 0; i < 16; i++) begin
                exp_t e;
                e.data = mq.pop_front();
                e.idx  = 4'(i);
                e.sop  = (i == 0);
                e.eop  = (i == 15);
                exp_q.push_back(e);
            end
            m_pend--;
        end
    endtask

    task automatic model_corr();
        if (m_pend < 7) m_pend++;
        model_update();
    endtask

    // Monitor: compares every presented output against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_out: got data %0d with no expectation at %0t", fifo_dout, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", int'(fifo_dout), int'(e.data));
                check("out_idx",  int'(out_idx),   int'(e.idx));
                check("out_sop",  int'(out_sop),   int'(e.sop));
                check("out_eop",  int'(out_eop),   int'(e.eop));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_sym(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        check("in_ready_wr", int'(in_ready), 1);
        mq.push_back(d);
        tick();
        in_valid = 1'b0;
        model_update();
    endtask

    task automatic pulse_corr();
        corr_start = 1'b1;
        tick();
        corr_start = 1'b0;
        model_corr();
    endtask

    task automatic do_reset(input bit chk_drained);
        if (chk_drained) check("drained", exp_q.size(), 0);
        in_valid = 1'b0; corr_start = 1'b0; rst_n = 1'b0;
        exp_q.delete(); mq.delete(); m_pend = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_cycles, run, acc, acc2;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_fifo_rst", int'(fifo_rst), 1);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_fifo_rd", int'(fifo_rd), 0);
        check("rst_fifo_wr", int'(fifo_wr), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_idx", int'(out_idx), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cw_stored", int'(cw_stored), 0);
        check("rst_err", int'(err_pend_ovf), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        check("rel_fifo_rst", int'(fifo_rst), 1);
        check("rel_in_ready", int'(in_ready), 0);
        tick();
        check("post_fifo_rst", int'(fifo_rst), 0);
        check("post_in_ready", int'(in_ready), 1);

        // One codeword, one request: latency and burst length
        for (int i = 0; i < 16; i++) write_sym(8'(i));
        check("t1_cw_stored_1", int'(cw_stored), 1);
        pulse_corr();
        check("t1_e0_busy", int'(busy), 0);
        check("t1_e0_valid", int'(out_valid), 0);
        check("t1_e0_cw", int'(cw_stored), 1);
        tick();
        check("t1_e1_busy", int'(busy), 1);
        check("t1_e1_cw", int'(cw_stored), 0);
        check("t1_e1_valid", int'(out_valid), 0);
        rd_cycles = 0;
        for (int k = 0; k < 30; k++) begin
            if (fifo_rd) rd_cycles++;
            tick();
            if (k == 0) check("t1_e2_valid", int'(out_valid), 1);
        end
        check("t1_rd_cycles", rd_cycles, 16);
        check("t1_busy_end", int'(busy), 0);

        // Two codewords, back-to-back requests
        for (int i = 0; i < 32; i++) write_sym(8'(8'h20 + i));
        check("t2_cw_stored", int'(cw_stored), 2);
        corr_start = 1'b1;
        tick();
        model_corr();
        tick();
        corr_start = 1'b0;
        model_corr();
        run = 0;
        while (!out_valid && run < 20) begin run++; tick(); end
        check("t2_valid_seen", int'(out_valid), 1);
        run = 0;
        while (out_valid && run < 40) begin run++; tick(); end
        check("t2_run_len", run, 32);
        check("t2_busy_end", int'(busy), 0);
        for (int i = 0; i < 16; i++) write_sym(8'(8'h40 + i));
        repeat (5) tick();
        check("t2_pend_empty", int'(busy), 0);
        do_reset(1'b1);

        // Fill to capacity, then one read burst with in_valid held
        in_valid = 1'b1;
        acc = 0;
        for (int k = 0; k < 150; k++) begin
            in_data = 8'(acc);
            if (in_ready) begin mq.push_back(in_data); acc++; end
            tick();
        end
        check("t3_accepted", acc, 132);
        check("t3_full_ready", int'(in_ready), 0);
        check("t3_cw_stored", int'(cw_stored), 8);
        corr_start = 1'b1;
        tick();
        corr_start = 1'b0;
        model_corr();
        check("t3_e0_ready", int'(in_ready), 0);
        tick();
        check("t3_e1_rd", int'(fifo_rd), 1);
        check("t3_e1_ready", int'(in_ready), 0);
        tick();
        check("t3_e2_ready", int'(in_ready), 1);
        acc2 = 0;
        for (int k = 0; k < 30; k++) begin
            in_data = 8'(200 + acc2);
            if (in_ready) begin mq.push_back(in_data); acc2++; end
            tick();
        end
        in_valid = 1'b0;
        check("t3_accepted2", acc2, 16);
        check("t3_ready_end", int'(in_ready), 0);
        check("t3_cw_end", int'(cw_stored), 8);
        do_reset(1'b1);

        // Early request waits for its codeword
        for (int i = 0; i < 10; i++) write_sym(8'(8'h50 + i));
        pulse_corr();
        for (int k = 0; k < 3; k++) begin
            check("t4_wait_rd", int'(fifo_rd), 0);
            tick();
        end
        for (int i = 10; i < 16; i++) write_sym(8'(8'h50 + i));
        check("t4_cw_1", int'(cw_stored), 1);
        check("t4_not_yet", int'(busy), 0);
        tick();
        check("t4_started", int'(busy), 1);
        repeat (20) tick();
        check("t4_done", int'(busy), 0);
        do_reset(1'b1);

        // Pending-counter saturation
        corr_start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("t5_err_before", int'(err_pend_ovf), 0);
            tick();
        end
        corr_start = 1'b0;
        check("t5_err_set", int'(err_pend_ovf), 1);
        repeat (3) tick();
        check("t5_err_sticky", int'(err_pend_ovf), 1);
        do_reset(1'b1);

        // Reset during cycle 5 of a burst
        for (int i = 0; i < 16; i++) write_sym(8'(8'h60 + i));
        pulse_corr();
        tick();
        check("t6_busy", int'(busy), 1);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("t6_rd_off", int'(fifo_rd), 0);
        check("t6_valid_off", int'(out_valid), 0);
        check("t6_busy_off", int'(busy), 0);
        check("t6_fifo_rst", int'(fifo_rst), 1);
        check("t6_cw_zero", int'(cw_stored), 0);
        exp_q.delete(); mq.delete(); m_pend = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        check("t6_rel_fifo_rst", int'(fifo_rst), 1);
        check("t6_rel_ready", int'(in_ready), 0);
        tick();
        check("t6_post_fifo_rst", int'(fifo_rst), 0);
        check("t6_post_ready", int'(in_ready), 1);
        for (int i = 0; i < 16; i++) write_sym(8'(8'h70 + i));
        pulse_corr();
        repeat (25) tick();
        check("t6_busy_end", int'(busy), 0);
        check("t6_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rs_fifo_ctrl.md
Name: rs_fifo_ctrl

Overview:
- Sequences the decoder's received-symbol FIFO (8-bit, 132-deep, synchronous active-high reset, registered 1-cycle read) in the RS(16,8) decoder.
- Writes incoming symbols with backpressure and counts complete 16-symbol codewords.
- Queues "correction ready" requests from the Chien/Forney stage, then reads each buffered codeword as a contiguous 16-cycle burst aligned to the error-value stream.
- Also drives the FIFO's reset and flags protocol errors.

Parameters:
- WIDTH, 8, symbol width.
- N, 16, symbols per codeword.
- DEPTH, 132, FIFO depth in symbols; must match the FIFO instance.
- PEND_W, 3, width of the pending-request counter (max 7 queued requests).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input symbol valid.
- in_data  in  WIDTH  input symbol.
- in_ready  out  1  controller accepts the symbol this cycle.
- corr_start  in  1  one-cycle pulse: correction data for the oldest unread codeword is ready.
- fifo_rst  out  1  to FIFO rst.
- fifo_wr  out  1  to FIFO wr.
- fifo_rd  out  1  to FIFO rd.
- fifo_din  out  WIDTH  to FIFO datain.
- out_valid  out  1  FIFO dataout holds a valid codeword symbol.
- out_sop  out  1  first symbol of the codeword.
- out_eop  out  1  last symbol of the codeword.
- out_idx  out  4  symbol index 0..N-1 of the current output.
- cw_stored  out  4  complete codewords buffered and not yet read.
- busy  out  1  read burst in progress.
- err_pend_ovf  out  1  sticky: corr_start arrived while the pending counter was saturated.

Behaviour:
- Reset (async assert, sync release):
  - All counters, state and sticky flags are 0.
  - in_ready=0, fifo_wr=0, fifo_rd=0, out_* = 0.
  - fifo_rst=1 while rst_n is low and for exactly one clk cycle after release; it is a flop with async set.
  - in_ready is held 0 while fifo_rst=1.
- Occupancy:
  - sym_cnt (0..DEPTH) increments on fifo_wr only and decrements on fifo_rd only; it is unchanged when both are asserted.
  - in_ready = !fifo_rst && (sym_cnt < DEPTH), combinational.
  - The controller never relies on the FIFO's full/empty flags.
- Write path:
  - fifo_wr = in_valid && in_ready; fifo_din = in_data.
  - wr_idx counts 0..N-1 on each write and wraps to 0.
  - A write at wr_idx=N-1 increments cw_stored.
  - in_ready=0 holds wr_idx; nothing is dropped.
- Pending counter pend:
  - +1 on corr_start; -1 on burst start; unchanged if both happen in the same cycle.
  - corr_start while pend is at its maximum with no burst start in that cycle: request dropped, err_pend_ovf set. It is cleared only by reset.
- FSM states IDLE and READ:
  - IDLE -> READ at an edge where pend>0 && cw_stored>0, using registered values. This is a burst start: rd_idx:=0, pend-1, cw_stored-1.
  - READ: fifo_rd=1 and busy=1 on every cycle; rd_idx increments by 1.
  - At rd_idx=N-1: if pend>0 && cw_stored>0, the next burst starts back-to-back (stay in READ, rd_idx:=0, both counters decrement). Otherwise go to IDLE.
  - A burst start and a codeword-completing write in the same cycle leave cw_stored unchanged.
- Output alignment:
  - out_valid, out_sop, out_eop and out_idx are fifo_rd, (rd_idx==0), (rd_idx==N-1) and rd_idx, each registered one cycle, so they align with the FIFO's registered dataout.
- Latency:
  - corr_start sampled at edge E0 with a codeword already stored: READ from E1, first out_valid after E2.
  - Back-to-back bursts produce 32 consecutive out_valid cycles with no gap.
- Early request: corr_start before its codeword is complete waits in pend. The burst starts at the edge after cw_stored becomes nonzero.
- Width rules:
  - sym_cnt is $clog2(DEPTH+1) bits.
  - cw_stored saturates logically at DEPTH/N (8); backpressure prevents overflow.
- Reset mid-burst: everything returns to reset values immediately. The FIFO is cleared via fifo_rst, and any partial codeword is discarded.

Test Plan:
- Reset, then write 16 symbols 0x00..0x0F, then one corr_start pulse -> cw_stored=1 then 0 at burst start; fifo_rd high for 16 cycles; out_valid 16 cycles with data 0x00..0x0F; out_sop on 0x00, out_eop on 0x0F; first out_valid 3 edges after corr_start.
- Write 2 codewords, then two corr_start pulses on consecutive cycles -> 32 contiguous out_valid cycles, out_idx 0..15 twice, pend ends at 0, busy drops after the 32nd read.
- Hold in_valid=1 with no reads -> exactly 132 writes accepted, then in_ready=0; cw_stored=8 with 4 symbols of a partial codeword; issue one corr_start -> in_ready returns the cycle after the first read; simultaneous read and write keeps sym_cnt at 132.
- Pulse corr_start after only 10 symbols written -> no fifo_rd; finish the remaining 6 symbols -> burst starts the edge after cw_stored=1.
- With no codewords stored, send 8 corr_start pulses -> pend saturates at 7; err_pend_ovf=1 after the 8th pulse and stays set.
- Assert rst_n low during cycle 5 of a burst -> fifo_rd, out_valid and busy go 0 immediately; fifo_rst is high through reset plus 1 cycle; in_ready=0 during that cycle, then 1.
